// File: rtl/coefficient_responder.sv
// ---------------------------------------------------------------------------
// coefficient_responder
//
// Datapath-side end of the FIR coefficient-load handshake. A load request is
// captured into staging registers, modwait is held high for WRITE_LAT cycles,
// and then the staged value is committed into one of four coefficient slots.
// A clear request zeroes every slot and aborts any write still in flight.
//
// Ports:
//   clk             in   system clock, rising edge
//   n_rst           in   asynchronous active-low reset
//   clear_coeff     in   one-cycle request: zero all coefficients
//   load_coeff      in   one-cycle request: write coeff_in to coefficient_num
//   coefficient_num in   [1:0] target slot, sampled with load_coeff
//   coeff_in        in   [DATA_W-1:0] coefficient value, sampled with load_coeff
//   modwait         out  busy while an accepted load is being committed
//   fir_coeffs      out  [4*DATA_W-1:0] slot k at bits [k*DATA_W +: DATA_W]
//   coeff_valid     out  all four slots written since the last clear
//   coeff_set_done  out  one-cycle pulse when coeff_valid rises
//   protocol_err    out  one-cycle pulse on an illegal request
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module coefficient_responder #(
  parameter int DATA_W    = 16,
  parameter int WRITE_LAT = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  clear_coeff,
  input  logic                  load_coeff,
  input  logic [1:0]            coefficient_num,
  input  logic [DATA_W-1:0]     coeff_in,
  output logic                  modwait,
  output logic [4*DATA_W-1:0]   fir_coeffs,
  output logic                  coeff_valid,
  output logic                  coeff_set_done,
  output logic                  protocol_err
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // Counter preload: the load edge itself accounts for the first busy cycle,
  // so the counter only has to cover the remaining WRITE_LAT-1 cycles.
  localparam logic [3:0] LAT_M1 = 4'(WRITE_LAT - 1);

  state_t                state_q,      state_d;
  logic                  modwait_q,    modwait_d;
  logic [3:0]            cnt_q,        cnt_d;
  logic [DATA_W-1:0]     stage_data_q, stage_data_d;
  logic [1:0]            stage_num_q,  stage_num_d;
  logic [4*DATA_W-1:0]   fir_q,        fir_d;
  logic [3:0]            mask_q,       mask_d;
  logic                  valid_q,      valid_d;
  logic                  set_done_q,   set_done_d;
  logic                  perr_q,       perr_d;

  // Written-slot mask as it will be after committing the staged slot.
  logic [3:0]            mask_commit_s;

  // Mask update for the slot currently staged.
  always_comb begin
    mask_commit_s = mask_q | (4'b0001 << stage_num_q);
  end

  // Next-state and next-output logic for the IDLE/WRITE handshake.
  always_comb begin
    state_d      = state_q;
    modwait_d    = modwait_q;
    cnt_d        = cnt_q;
    stage_data_d = stage_data_q;
    stage_num_d  = stage_num_q;
    fir_d        = fir_q;
    mask_d       = mask_q;
    valid_d      = valid_q;
    set_done_d   = 1'b0;
    perr_d       = 1'b0;

    // Clear+load together is always illegal; a load while busy is too.
    if (clear_coeff && load_coeff) begin
      perr_d = 1'b1;
    end else if ((state_q == WRITE) && load_coeff) begin
      perr_d = 1'b1;
    end else begin
      perr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (clear_coeff) begin
          fir_d   = '0;
          mask_d  = 4'b0000;
          valid_d = 1'b0;
        end else if (load_coeff) begin
          stage_data_d = coeff_in;
          stage_num_d  = coefficient_num;
          modwait_d    = 1'b1;
          cnt_d        = LAT_M1;
          state_d      = WRITE;
        end else begin
          state_d = IDLE;
        end
      end

      WRITE: begin
        if (clear_coeff) begin
          // Abort: the staged value is discarded, never reaching its slot.
          fir_d     = '0;
          mask_d    = 4'b0000;
          valid_d   = 1'b0;
          modwait_d = 1'b0;
          cnt_d     = 4'd0;
          state_d   = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          fir_d[stage_num_q*DATA_W +: DATA_W] = stage_data_q;
          mask_d    = mask_commit_s;
          modwait_d = 1'b0;
          state_d   = IDLE;
          // Only the first completion of a set raises valid; reloading a
          // slot afterwards leaves valid alone and produces no pulse.
          if ((mask_commit_s == 4'b1111) && !valid_q) begin
            valid_d    = 1'b1;
            set_done_d = 1'b1;
          end else begin
            valid_d = valid_q;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        modwait_d = 1'b0;
        cnt_d     = 4'd0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      modwait_q    <= 1'b0;
      cnt_q        <= 4'd0;
      stage_data_q <= '0;
      stage_num_q  <= 2'd0;
      fir_q        <= '0;
      mask_q       <= 4'b0000;
      valid_q      <= 1'b0;
      set_done_q   <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      modwait_q    <= modwait_d;
      cnt_q        <= cnt_d;
      stage_data_q <= stage_data_d;
      stage_num_q  <= stage_num_d;
      fir_q        <= fir_d;
      mask_q       <= mask_d;
      valid_q      <= valid_d;
      set_done_q   <= set_done_d;
      perr_q       <= perr_d;
    end
  end

  assign modwait        = modwait_q;
  assign fir_coeffs     = fir_q;
  assign coeff_valid    = valid_q;
  assign coeff_set_done = set_done_q;
  assign protocol_err   = perr_q;

endmodule

// File: tb/tb_coefficient_responder.sv
// ---------------------------------------------------------------------------
// Directed bench for coefficient_responder. Three instances (WRITE_LAT = 1, 2
// and 5) share clock, reset, clear and data inputs; each has its own
// load_coeff so the handshake can be exercised on one instance at a time.
// ---------------------------------------------------------------------------
module tb_coefficient_responder;

  logic        clk;
  logic        n_rst;
  logic        clear_coeff;
  logic [2:0]  load_v;            // 0: lat1, 1: lat2, 2: lat5
  logic [1:0]  coefficient_num;
  logic [15:0] coeff_in;

  logic [2:0]  mw_v;
  logic [63:0] fir_v [3];
  logic [2:0]  valid_v;
  logic [2:0]  done_v;
  logic [2:0]  perr_v;

  int total;
  int bad;

  coefficient_responder #(.DATA_W(16), .WRITE_LAT(1)) u_lat1 (
    .clk(clk), .n_rst(n_rst), .clear_coeff(clear_coeff), .load_coeff(load_v[0]),
    .coefficient_num(coefficient_num), .coeff_in(coeff_in), .modwait(mw_v[0]),
    .fir_coeffs(fir_v[0]), .coeff_valid(valid_v[0]), .coeff_set_done(done_v[0]),
    .protocol_err(perr_v[0]));

  coefficient_responder #(.DATA_W(16), .WRITE_LAT(2)) u_lat2 (
    .clk(clk), .n_rst(n_rst), .clear_coeff(clear_coeff), .load_coeff(load_v[1]),
    .coefficient_num(coefficient_num), .coeff_in(coeff_in), .modwait(mw_v[1]),
    .fir_coeffs(fir_v[1]), .coeff_valid(valid_v[1]), .coeff_set_done(done_v[1]),
    .protocol_err(perr_v[1]));

  coefficient_responder #(.DATA_W(16), .WRITE_LAT(5)) u_lat5 (
    .clk(clk), .n_rst(n_rst), .clear_coeff(clear_coeff), .load_coeff(load_v[2]),
    .coefficient_num(coefficient_num), .coeff_in(coeff_in), .modwait(mw_v[2]),
    .fir_coeffs(fir_v[2]), .coeff_valid(valid_v[2]), .coeff_set_done(done_v[2]),
    .protocol_err(perr_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One full handshake on instance sel; returns how many cycles modwait was high.
  task automatic do_load(input int sel, input logic [1:0] num, input logic [15:0] data,
                         output int hi);
    coefficient_num = num;
    coeff_in        = data;
    load_v[sel]     = 1'b1;
    cycle();
    load_v[sel]     = 1'b0;
    hi = 0;
    while (mw_v[sel] && hi < 20) begin
      hi++;
      cycle();
    end
  endtask

  task automatic pulse_clear();
    clear_coeff = 1'b1;
    cycle();
    clear_coeff = 1'b0;
  endtask

  // Full set load on one instance, checking latency and set-done timing.
  task automatic full_set(input int sel, input int lat, input string nm);
    int hi;
    pulse_clear();
    chk({nm, "_clr_fir"}, fir_v[sel], 64'h0);
    chk({nm, "_clr_valid"}, {63'd0, valid_v[sel]}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      do_load(sel, 2'(k), 16'((k + 1) * 256), hi);
      chk({nm, "_mw_len"}, 64'(hi), 64'(lat));
      chk({nm, "_done"}, {63'd0, done_v[sel]}, (k == 3) ? 64'd1 : 64'd0);
      chk({nm, "_valid"}, {63'd0, valid_v[sel]}, (k == 3) ? 64'd1 : 64'd0);
    end
    chk({nm, "_fir_full"}, fir_v[sel], 64'h0400_0300_0200_0100);
    cycle();
    chk({nm, "_done_drop"}, {63'd0, done_v[sel]}, 64'd0);
    chk({nm, "_valid_hold"}, {63'd0, valid_v[sel]}, 64'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n_rst = 1'b0;
    load_v = 3'b000;
    clear_coeff = 1'b0;
    coefficient_num = 2'd0;
    coeff_in = 16'h0;

    // 1: reset with random inputs, then idle after release.
    for (int i = 0; i < 4; i++) begin
      clear_coeff     = 1'($urandom);
      load_v          = 3'($urandom);
      coefficient_num = 2'($urandom);
      coeff_in        = 16'($urandom);
      cycle();
    end
    chk("rst_mw", {61'd0, mw_v}, 64'd0);
    chk("rst_fir", fir_v[1], 64'h0);
    chk("rst_flags", {55'd0, valid_v, done_v, perr_v}, 64'd0);
    clear_coeff = 1'b0;
    load_v = 3'b000;
    #2 n_rst = 1'b1;
    cycle(); cycle(); cycle();
    chk("idle_mw", {61'd0, mw_v}, 64'd0);
    chk("idle_fir", fir_v[1], 64'h0);
    chk("idle_flags", {55'd0, valid_v, done_v, perr_v}, 64'd0);

    // 2: full handshake with WRITE_LAT = 2.
    full_set(1, 2, "lat2");

    // 3: illegal load during the second busy cycle of a slot-1 load.
    coefficient_num = 2'd1;
    coeff_in = 16'h1111;
    load_v[1] = 1'b1;
    cycle();
    load_v[1] = 1'b0;
    chk("s3_mw_c1", {63'd0, mw_v[1]}, 64'd1);
    cycle();
    chk("s3_mw_c2", {63'd0, mw_v[1]}, 64'd1);
    coefficient_num = 2'd2;
    coeff_in = 16'hBEEF;
    load_v[1] = 1'b1;
    cycle();
    load_v[1] = 1'b0;
    chk("s3_perr", {63'd0, perr_v[1]}, 64'd1);
    chk("s3_mw_drop", {63'd0, mw_v[1]}, 64'd0);
    chk("s3_fir", fir_v[1], 64'h0400_0300_1111_0100);
    chk("s3_no_done", {63'd0, done_v[1]}, 64'd0);
    cycle();
    chk("s3_perr_drop", {63'd0, perr_v[1]}, 64'd0);
    chk("s3_mw_idle", {63'd0, mw_v[1]}, 64'd0);
    chk("s3_fir_hold", fir_v[1], 64'h0400_0300_1111_0100);

    // 4: clear aborts a write of 0x5555 to slot 0.
    coefficient_num = 2'd0;
    coeff_in = 16'h5555;
    load_v[1] = 1'b1;
    cycle();
    load_v[1] = 1'b0;
    chk("s4_mw", {63'd0, mw_v[1]}, 64'd1);
    clear_coeff = 1'b1;
    cycle();
    clear_coeff = 1'b0;
    chk("s4_mw_abort", {63'd0, mw_v[1]}, 64'd0);
    chk("s4_fir", fir_v[1], 64'h0);
    chk("s4_valid", {63'd0, valid_v[1]}, 64'd0);
    chk("s4_perr", {63'd0, perr_v[1]}, 64'd0);
    cycle(); cycle(); cycle();
    chk("s4_fir_stay", fir_v[1], 64'h0);
    chk("s4_mw_stay", {63'd0, mw_v[1]}, 64'd0);

    // 5: clear and load together, then reset mid-write.
    coefficient_num = 2'd3;
    coeff_in = 16'h7777;
    clear_coeff = 1'b1;
    load_v[1] = 1'b1;
    cycle();
    clear_coeff = 1'b0;
    load_v[1] = 1'b0;
    chk("s5_perr", {63'd0, perr_v[1]}, 64'd1);
    chk("s5_fir", fir_v[1], 64'h0);
    chk("s5_mw", {63'd0, mw_v[1]}, 64'd0);
    cycle();
    chk("s5_perr_drop", {63'd0, perr_v[1]}, 64'd0);
    chk("s5_mw_idle", {63'd0, mw_v[1]}, 64'd0);
    coefficient_num = 2'd3;
    coeff_in = 16'hAAAA;
    load_v[1] = 1'b1;
    cycle();
    load_v[1] = 1'b0;
    chk("s5_mw_write", {63'd0, mw_v[1]}, 64'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("s5_rst_mw", {63'd0, mw_v[1]}, 64'd0);
    chk("s5_rst_fir", fir_v[1], 64'h0);
    chk("s5_rst_flags", {61'd0, valid_v[1], done_v[1], perr_v[1]}, 64'd0);
    #3 n_rst = 1'b1;
    cycle(); cycle(); cycle();
    chk("s5_lost_fir", fir_v[1], 64'h0);
    chk("s5_lost_mw", {63'd0, mw_v[1]}, 64'd0);

    // 6: same handshake with WRITE_LAT = 1 and WRITE_LAT = 5.
    full_set(0, 1, "lat1");
    full_set(2, 5, "lat5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
